servo_waypoint_seq: RTL and testbench

Waypoint sequencer for one servo channel. It stores up to 16 (angle, dwell) waypoints and steps through them on command. It drives the target-angle input of the servo slew/PWM stage. It waits a conservative settle time per move plus a programmable dwell, then advances, optionally looping. It sits between the user/command logic and the servo slew stage, and owns the only path to that stage's angle input.

---
 rtl/servo_waypoint_seq.sv | 157 +++++++++++++++
 tb/tb_servo_waypoint_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_waypoint_seq.sv
// Waypoint sequencer for one servo channel: it steps through up to 16 (angle, dwell)
// waypoints and drives the target angle of the slew stage, waiting for settle and dwell.
module servo_waypoint_seq #(
    parameter int unsigned STEP_CYCLES = 32768,
    parameter int unsigned DWELL_TICK  = 50000,
    parameter int unsigned INIT_ANGLE  = 100
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iWrEn,
    input  logic [3:0]  iWrAddr,
    input  logic [9:0]  iWrAngle,
    input  logic [15:0] iWrDwell,
    input  logic [4:0]  iLen,
    input  logic        iLoop,
    input  logic        iStart,
    input  logic        iStop,
    output logic [9:0]  oAngle,
    output logic [3:0]  oIdx,
    output logic        oBusy,
    output logic        oDone,
    output logic        oWrErr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MOVE,
        S_DWELL,
        S_NEXT
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  idx_reg, idx_next;
    logic [4:0]  len_reg, len_next;
    logic [31:0] cnt_reg, cnt_next;
    logic [9:0]  angle_reg, angle_next;
    logic        done_reg, done_next;
    logic        wr_err_reg, wr_err_next;

    logic [9:0]  wp_angle [16];
    logic [15:0] wp_dwell [16];

    logic        wr_ok;
    logic [9:0]  wr_angle;
    logic [9:0]  cur_angle;
    logic [15:0] cur_dwell;
    logic [9:0]  angle_diff;
    logic [23:0] move_cycles;
    logic [31:0] dwell_cycles;

    // Waypoint table is deliberately left out of reset so a reset keeps the program.
    assign wr_ok    = iWrEn && (state_reg == S_IDLE);
    assign wr_angle = (iWrAngle > 10'd180) ? 10'd180 : iWrAngle;

    always_ff @(posedge iClk) begin
        if (wr_ok) begin
            wp_angle[iWrAddr] <= wr_angle;
            wp_dwell[iWrAddr] <= iWrDwell;
        end
    end

    assign cur_angle    = wp_angle[idx_reg];
    assign cur_dwell    = wp_dwell[idx_reg];
    assign angle_diff   = (cur_angle >= angle_reg) ? (cur_angle - angle_reg)
                                                   : (angle_reg - cur_angle);
    assign move_cycles  = 24'(angle_diff) * 24'(STEP_CYCLES);
    assign dwell_cycles = 32'(cur_dwell) * 32'(DWELL_TICK);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_reg  <= S_IDLE;
            idx_reg    <= '0;
            len_reg    <= '0;
            cnt_reg    <= '0;
            angle_reg  <= 10'(INIT_ANGLE);
            done_reg   <= 1'b0;
            wr_err_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            len_reg    <= len_next;
            cnt_reg    <= cnt_next;
            angle_reg  <= angle_next;
            done_reg   <= done_next;
            wr_err_reg <= wr_err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        len_next    = len_reg;
        cnt_next    = cnt_reg;
        angle_next  = angle_reg;
        done_next   = 1'b0;
        wr_err_next = iWrEn && (state_reg != S_IDLE);

        case (state_reg)
            S_IDLE: begin
                if (iStart && !iStop && (iLen != 5'd0)) begin
                    state_next = S_LOAD;
                    idx_next   = '0;
                    len_next   = (iLen > 5'd16) ? 5'd16 : iLen;
                end
            end
            S_LOAD: begin
                angle_next = cur_angle;
                cnt_next   = {8'd0, move_cycles};
                state_next = S_MOVE;
            end
            S_MOVE: begin
                if (cnt_reg == 32'd0) begin
                    cnt_next   = dwell_cycles;
                    state_next = S_DWELL;
                end else begin
                    cnt_next = cnt_reg - 32'd1;
                end
            end
            S_DWELL: begin
                if (cnt_reg == 32'd0) begin
                    state_next = S_NEXT;
                end else begin
                    cnt_next = cnt_reg - 32'd1;
                end
            end
            S_NEXT: begin
                if ({1'b0, idx_reg} < (len_reg - 5'd1)) begin
                    idx_next   = idx_reg + 4'd1;
                    state_next = S_LOAD;
                end else if (iLoop) begin
                    idx_next   = '0;
                    state_next = S_LOAD;
                end else begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Abort wins over everything; the slew target stays where it was.
        if (iStop && (state_reg != S_IDLE)) begin
            state_next = S_IDLE;
            angle_next = angle_reg;
            cnt_next   = '0;
            done_next  = 1'b0;
        end
    end

    assign oAngle = angle_reg;
    assign oIdx   = idx_reg;
    assign oBusy  = (state_reg != S_IDLE);
    assign oDone  = done_reg;
    assign oWrErr = wr_err_reg;

endmodule

// File: tb/tb_servo_waypoint_seq.sv
// Directed bench for servo_waypoint_seq; expected oAngle changes are queued as runs start
// and popped by a monitor whenever the DUT moves its target angle.
module tb_servo_waypoint_seq;

    logic        iClk = 1'b0;
    logic        iRst = 1'b0;
    logic        iWrEn = 1'b0;
    logic [3:0]  iWrAddr = '0;
    logic [9:0]  iWrAngle = '0;
    logic [15:0] iWrDwell = '0;
    logic [4:0]  iLen = '0;
    logic        iLoop = 1'b0;
    logic        iStart = 1'b0;
    logic        iStop = 1'b0;
    logic [9:0]  oAngle;
    logic [3:0]  oIdx;
    logic        oBusy;
    logic        oDone;
    logic        oWrErr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [9:0] exp_q [$];
    logic [9:0] prev_angle = 'x;

    servo_waypoint_seq #(
        .STEP_CYCLES(4),
        .DWELL_TICK (2),
        .INIT_ANGLE (100)
    ) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iWrEn   (iWrEn),
        .iWrAddr (iWrAddr),
        .iWrAngle(iWrAngle),
        .iWrDwell(iWrDwell),
        .iLen    (iLen),
        .iLoop   (iLoop),
        .iStart  (iStart),
        .iStop   (iStop),
        .oAngle  (oAngle),
        .oIdx    (oIdx),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oWrErr  (oWrErr)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iClk);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [9:0] ang, input logic [15:0] dw);
        iWrEn    = 1'b1;
        iWrAddr  = a;
        iWrAngle = ang;
        iWrDwell = dw;
        tick(1);
        iWrEn = 1'b0;
        chk("wr_idle_no_err", oWrErr, 0);
        $display("write addr=%0d angle=%0d dwell=%0d", a, ang, dw);
    endtask

    task automatic start(input logic [4:0] len, input logic loop);
        iLen   = len;
        iLoop  = loop;
        iStart = 1'b1;
        tick(1);
        iStart = 1'b0;
        $display("start len=%0d loop=%0d busy=%0d", len, loop, oBusy);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (oDone !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        chk({tag, "_done"}, oDone, 1);
        chk({tag, "_busy_low"}, oBusy, 0);
        tick(1);
        chk({tag, "_done_pulse"}, oDone, 0);
        $display("run %s finished after %0d cycles", tag, k);
    endtask

    // Scoreboard consumer: every change of oAngle must match the next queued target.
    always begin
        @(posedge iClk);
        #1;
        if (oAngle !== prev_angle) begin
            if (exp_q.size() == 0) begin
                chk("angle_unexpected", 32'(oAngle), 32'(prev_angle));
            end else begin
                chk("angle_sb", 32'(oAngle), 32'(exp_q.pop_front()));
            end
            $display("angle change %0d -> %0d", prev_angle, oAngle);
            prev_angle = oAngle;
        end
    end

    initial begin
        // Reset
        exp_q.push_back(10'd100);
        iRst = 1'b1;
        tick(2);
        iRst = 1'b0;
        chk("rst_angle", oAngle, 100);
        chk("rst_busy", oBusy, 0);
        chk("rst_idx", oIdx, 0);
        chk("rst_done", oDone, 0);
        chk("rst_wrerr", oWrErr, 0);

        // Two-point run
        wr(4'd0, 10'd104, 16'd1);
        wr(4'd1, 10'd100, 16'd0);
        exp_q.push_back(10'd104);
        exp_q.push_back(10'd100);
        start(5'd2, 1'b0);
        chk("run2_busy_e0", oBusy, 1);
        chk("run2_angle_e0", oAngle, 100);
        tick(1);
        chk("run2_angle_e1", oAngle, 104);
        tick(21);
        chk("run2_idx_e22", oIdx, 1);
        chk("run2_angle_e22", oAngle, 104);
        tick(1);
        chk("run2_angle_e23", oAngle, 100);
        tick(18);
        chk("run2_done_e41", oDone, 0);
        chk("run2_busy_e41", oBusy, 1);
        tick(1);
        chk("run2_done_e42", oDone, 1);
        chk("run2_busy_e42", oBusy, 0);
        tick(1);
        chk("run2_done_e43", oDone, 0);

        // Loop then stop
        exp_q.push_back(10'd104);
        exp_q.push_back(10'd100);
        exp_q.push_back(10'd104);
        start(5'd2, 1'b1);
        tick(42);
        chk("loop_idx_e42", oIdx, 0);
        chk("loop_done_e42", oDone, 0);
        chk("loop_busy_e42", oBusy, 1);
        tick(1);
        chk("loop_angle_e43", oAngle, 104);
        iStop = 1'b1;
        tick(1);
        iStop = 1'b0;
        chk("stop_busy", oBusy, 0);
        chk("stop_angle", oAngle, 104);
        chk("stop_done", oDone, 0);
        tick(5);
        chk("stop_hold_angle", oAngle, 104);
        chk("stop_hold_busy", oBusy, 0);

        // Write while busy (wp0 equals current angle, so MOVE is one cycle)
        exp_q.push_back(10'd100);
        start(5'd2, 1'b0);
        tick(1);
        iWrEn    = 1'b1;
        iWrAddr  = 4'd0;
        iWrAngle = 10'd50;
        iWrDwell = 16'd9;
        tick(1);
        iWrEn = 1'b0;
        chk("busy_wr_err", oWrErr, 1);
        tick(1);
        chk("busy_wr_err_pulse", oWrErr, 0);
        wait_done("busy_wr", 200);
        exp_q.push_back(10'd104);
        exp_q.push_back(10'd100);
        start(5'd2, 1'b0);
        tick(1);
        chk("wp0_kept_angle", oAngle, 104);
        tick(21);
        chk("wp0_kept_dwell_idx", oIdx, 1);
        wait_done("rerun", 200);

        // Clamp
        wr(4'd0, 10'd300, 16'd0);
        exp_q.push_back(10'd180);
        start(5'd1, 1'b0);
        tick(1);
        chk("clamp_angle", oAngle, 180);
        wait_done("clamp", 1000);

        // iLen=0 start is ignored; start+stop together stays idle
        wr(4'd0, 10'd90, 16'd0);
        start(5'd0, 1'b0);
        chk("len0_busy", oBusy, 0);
        tick(3);
        chk("len0_busy_later", oBusy, 0);
        iStop = 1'b1;
        start(5'd1, 1'b0);
        iStop = 1'b0;
        chk("startstop_busy", oBusy, 0);
        tick(3);
        chk("startstop_busy_later", oBusy, 0);
        chk("startstop_angle", oAngle, 180);

        // Reset mid-DWELL of waypoint 1, then rerun from waypoint 0
        wr(4'd0, 10'd176, 16'd0);
        wr(4'd1, 10'd172, 16'd2);
        exp_q.push_back(10'd176);
        exp_q.push_back(10'd172);
        start(5'd2, 1'b0);
        tick(1);
        chk("rd_angle_e1", oAngle, 176);
        tick(38);
        chk("rd_idx_e39", oIdx, 1);
        chk("rd_busy_e39", oBusy, 1);
        chk("rd_angle_e39", oAngle, 172);
        exp_q.push_back(10'd100);
        iRst = 1'b1;
        tick(1);
        iRst = 1'b0;
        chk("rd_rst_angle", oAngle, 100);
        chk("rd_rst_busy", oBusy, 0);
        chk("rd_rst_idx", oIdx, 0);
        chk("rd_rst_done", oDone, 0);
        chk("rd_rst_wrerr", oWrErr, 0);
        exp_q.push_back(10'd176);
        exp_q.push_back(10'd172);
        start(5'd2, 1'b0);
        tick(1);
        chk("rd_rerun_angle", oAngle, 176);
        chk("rd_rerun_idx", oIdx, 0);
        wait_done("rd_rerun", 2000);

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
